red_pitaya_hk_bus_arb: RTL and testbench

//  Two-requester arbiter sharing the single house-keeping system-bus slave (ID/DNA/LED/expansion regs).

---
 rtl/red_pitaya_hk_pkg.sv | 27 ++
 rtl/red_pitaya_bus_req_latch.sv | 61 ++++++
 rtl/red_pitaya_hk_bus_arb.sv | 207 ++++++++++++++++++++
 tb/tb_red_pitaya_hk_bus_arb.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/red_pitaya_hk_pkg.sv
// Shared definitions for the house-keeping bus arbiter: FSM encoding,
// default timing parameters, requester indices and the round-robin pick.
package red_pitaya_hk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RECOVER = 2'd3
  } arb_state_e;

  localparam int DEF_TMO = 255;
  localparam int DEF_RCV = 4;

  localparam int M_PS  = 0;
  localparam int M_SEQ = 1;

  // Round-robin pick between two candidates: on contention the requester
  // that was NOT granted last wins; otherwise the only candidate wins.
  function automatic logic rr_pick(input logic [1:0] cand, input logic last);
    if (cand == 2'b11) begin
      return ~last;
    end
    return cand[1];
  endfunction

endpackage

// File: rtl/red_pitaya_bus_req_latch.sv
// One-deep pending request latch for one requester. Captures a strobe while
// empty, drops (and flags) a strobe while a request is already held, and is
// emptied by the arbiter when the held request completes.
module red_pitaya_bus_req_latch #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic          wen,
  input  logic          ren,
  input  logic          clr,
  output logic          pend,
  output logic [AW-1:0] p_addr,
  output logic [DW-1:0] p_wdata,
  output logic          p_we,
  output logic          ovf
);

  logic          pend_reg;
  logic [AW-1:0] addr_reg;
  logic [DW-1:0] wdata_reg;
  logic          we_reg;
  logic          ovf_reg;

  // Capture into the empty latch, or flag a dropped strobe; a clear from the
  // arbiter empties the latch after any capture decision for this cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pend_reg  <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      we_reg    <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      ovf_reg <= 1'b0;
      if (wen || ren) begin
        if (pend_reg) begin
          ovf_reg <= 1'b1;
        end else begin
          pend_reg  <= 1'b1;
          addr_reg  <= addr;
          wdata_reg <= wdata;
          we_reg    <= wen;
        end
      end
      if (clr) begin
        pend_reg <= 1'b0;
      end
    end
  end

  assign pend    = pend_reg;
  assign p_addr  = addr_reg;
  assign p_wdata = wdata_reg;
  assign p_we    = we_reg;
  assign ovf     = ovf_reg;

endmodule

// File: rtl/red_pitaya_hk_bus_arb.sv
// Two-requester round-robin arbiter in front of the house-keeping bus slave.
// One slave access outstanding at a time; a slave that never acknowledges is
// timed out, answered with an error, and followed by a short recovery window
// in which stray acknowledges are discarded.
module red_pitaya_hk_bus_arb
  import red_pitaya_hk_pkg::*;
#(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int TMO = DEF_TMO,
  parameter int RCV = DEF_RCV
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_wdata_i,
  input  logic          m0_wen_i,
  input  logic          m0_ren_i,
  output logic [DW-1:0] m0_rdata_o,
  output logic          m0_err_o,
  output logic          m0_ack_o,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_wdata_i,
  input  logic          m1_wen_i,
  input  logic          m1_ren_i,
  output logic [DW-1:0] m1_rdata_o,
  output logic          m1_err_o,
  output logic          m1_ack_o,
  output logic [AW-1:0] s_addr_o,
  output logic [DW-1:0] s_wdata_o,
  output logic          s_wen_o,
  output logic          s_ren_o,
  input  logic [DW-1:0] s_rdata_i,
  input  logic          s_err_i,
  input  logic          s_ack_i,
  output logic          stat_tmo_o,
  output logic          stat_ovf_o
);

  localparam int TCW = $clog2(TMO + 1);
  localparam int RCW = $clog2(RCV + 1);

  // Requester inputs gathered into arrays indexed by requester number
  logic [AW-1:0] in_addr  [2];
  logic [DW-1:0] in_wdata [2];
  logic          in_wen   [2];
  logic          in_ren   [2];

  assign in_addr[M_PS]   = m0_addr_i;
  assign in_wdata[M_PS]  = m0_wdata_i;
  assign in_wen[M_PS]    = m0_wen_i;
  assign in_ren[M_PS]    = m0_ren_i;
  assign in_addr[M_SEQ]  = m1_addr_i;
  assign in_wdata[M_SEQ] = m1_wdata_i;
  assign in_wen[M_SEQ]   = m1_wen_i;
  assign in_ren[M_SEQ]   = m1_ren_i;

  // Per-requester latch outputs and the request each would present if granted
  logic          pend     [2];
  logic [AW-1:0] p_addr   [2];
  logic [DW-1:0] p_wdata  [2];
  logic          p_we     [2];
  logic [1:0]    ovf;
  logic [1:0]    clr;
  logic [1:0]    cand;
  logic [AW-1:0] sel_addr [2];
  logic [DW-1:0] sel_wdata[2];
  logic          sel_we   [2];

  // Arbiter state
  arb_state_e    state_reg;
  logic          owner_reg;
  logic          last_reg;
  logic [TCW-1:0] tcnt_reg;
  logic [RCW-1:0] rcnt_reg;
  logic [AW-1:0] s_addr_reg;
  logic [DW-1:0] s_wdata_reg;
  logic          s_wen_reg;
  logic          s_ren_reg;
  logic [1:0]    ack_reg;
  logic [1:0]    err_reg;
  logic [DW-1:0] rdata_reg [2];
  logic          tmo_reg;

  logic          tmo_hit;
  logic          complete;
  logic          grant;

  assign tmo_hit  = (tcnt_reg == TCW'(TMO - 1));
  assign complete = (state_reg == ST_WAIT) && (s_ack_i || tmo_hit);
  assign grant    = rr_pick(cand, last_reg);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      red_pitaya_bus_req_latch #(
        .AW(AW),
        .DW(DW)
      ) u_latch (
        .clk    (clk_i),
        .rstn   (rstn_i),
        .addr   (in_addr[gi]),
        .wdata  (in_wdata[gi]),
        .wen    (in_wen[gi]),
        .ren    (in_ren[gi]),
        .clr    (clr[gi]),
        .pend   (pend[gi]),
        .p_addr (p_addr[gi]),
        .p_wdata(p_wdata[gi]),
        .p_we   (p_we[gi]),
        .ovf    (ovf[gi])
      );

      // A strobe arriving in IDLE is granted in the same cycle it is latched,
      // so the grant path takes the live inputs when nothing is held yet.
      assign cand[gi]      = pend[gi] | in_wen[gi] | in_ren[gi];
      assign sel_addr[gi]  = pend[gi] ? p_addr[gi]  : in_addr[gi];
      assign sel_wdata[gi] = pend[gi] ? p_wdata[gi] : in_wdata[gi];
      assign sel_we[gi]    = pend[gi] ? p_we[gi]    : in_wen[gi];
      assign clr[gi]       = complete && (owner_reg == 1'(gi));
    end
  endgenerate

  // Arbiter FSM: grant, issue one strobe, wait for ack or timeout, recover
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_reg    <= ST_IDLE;
      owner_reg    <= 1'b0;
      last_reg     <= 1'b1;
      tcnt_reg     <= '0;
      rcnt_reg     <= '0;
      s_addr_reg   <= '0;
      s_wdata_reg  <= '0;
      s_wen_reg    <= 1'b0;
      s_ren_reg    <= 1'b0;
      ack_reg      <= '0;
      err_reg      <= '0;
      rdata_reg[0] <= '0;
      rdata_reg[1] <= '0;
      tmo_reg      <= 1'b0;
    end else begin
      s_wen_reg    <= 1'b0;
      s_ren_reg    <= 1'b0;
      ack_reg      <= '0;
      err_reg      <= '0;
      rdata_reg[0] <= '0;
      rdata_reg[1] <= '0;
      tmo_reg      <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (|cand) begin
            owner_reg   <= grant;
            s_addr_reg  <= sel_addr[grant];
            s_wdata_reg <= sel_wdata[grant];
            s_wen_reg   <= sel_we[grant];
            s_ren_reg   <= ~sel_we[grant];
            state_reg   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          tcnt_reg  <= '0;
          state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          if (s_ack_i) begin
            ack_reg[owner_reg]   <= 1'b1;
            err_reg[owner_reg]   <= s_err_i;
            rdata_reg[owner_reg] <= s_rdata_i;
            last_reg             <= owner_reg;
            state_reg            <= ST_IDLE;
          end else if (tmo_hit) begin
            ack_reg[owner_reg] <= 1'b1;
            err_reg[owner_reg] <= 1'b1;
            tmo_reg            <= 1'b1;
            last_reg           <= owner_reg;
            rcnt_reg           <= '0;
            state_reg          <= ST_RECOVER;
          end else begin
            tcnt_reg <= tcnt_reg + 1'b1;
          end
        end
        ST_RECOVER: begin
          if (rcnt_reg == RCW'(RCV - 1)) begin
            state_reg <= ST_IDLE;
          end else begin
            rcnt_reg <= rcnt_reg + 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign s_addr_o   = s_addr_reg;
  assign s_wdata_o  = s_wdata_reg;
  assign s_wen_o    = s_wen_reg;
  assign s_ren_o    = s_ren_reg;
  assign m0_ack_o   = ack_reg[M_PS];
  assign m0_err_o   = err_reg[M_PS];
  assign m0_rdata_o = rdata_reg[M_PS];
  assign m1_ack_o   = ack_reg[M_SEQ];
  assign m1_err_o   = err_reg[M_SEQ];
  assign m1_rdata_o = rdata_reg[M_SEQ];
  assign stat_tmo_o = tmo_reg;
  assign stat_ovf_o = |ovf;

endmodule

// File: tb/tb_red_pitaya_hk_bus_arb.sv
// Bench for the house-keeping bus arbiter: a transaction-level reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_red_pitaya_hk_bus_arb;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;
  localparam int RCV = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [AW-1:0] m_addr  [2];
  logic [DW-1:0] m_wdata [2];
  logic          m_wen   [2];
  logic          m_ren   [2];
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          m0_err, m1_err, m0_ack, m1_ack;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic          s_wen, s_ren;
  logic [DW-1:0] s_rdata = '0;
  logic          s_err = 1'b0;
  logic          slv_ack = 1'b0;
  logic          inj_ack = 1'b0;
  wire           s_ack = slv_ack | inj_ack;
  logic          stat_tmo, stat_ovf;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  red_pitaya_hk_bus_arb #(.AW(AW), .DW(DW), .TMO(TMO), .RCV(RCV)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .m0_addr_i(m_addr[0]), .m0_wdata_i(m_wdata[0]), .m0_wen_i(m_wen[0]), .m0_ren_i(m_ren[0]),
    .m0_rdata_o(m0_rdata), .m0_err_o(m0_err), .m0_ack_o(m0_ack),
    .m1_addr_i(m_addr[1]), .m1_wdata_i(m_wdata[1]), .m1_wen_i(m_wen[1]), .m1_ren_i(m_ren[1]),
    .m1_rdata_o(m1_rdata), .m1_err_o(m1_err), .m1_ack_o(m1_ack),
    .s_addr_o(s_addr), .s_wdata_o(s_wdata), .s_wen_o(s_wen), .s_ren_o(s_ren),
    .s_rdata_i(s_rdata), .s_err_i(s_err), .s_ack_i(s_ack),
    .stat_tmo_o(stat_tmo), .stat_ovf_o(stat_ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- slave: acknowledges slv_delay cycles after a strobe ----
  int slv_delay = 1;   // 0 = never acknowledge
  int slv_cd = 0;
  always @(negedge clk) begin
    slv_ack = 1'b0;
    if (slv_cd > 0) begin
      slv_cd--;
      if (slv_cd == 0) slv_ack = 1'b1;
    end
    if (((s_ren | s_wen) === 1'b1) && slv_delay > 0) slv_cd = slv_delay;
  end

  // ---------------- reference model (transaction level) --------------------
  bit            pq_valid [2];
  logic [AW-1:0] pq_addr  [2];
  logic [DW-1:0] pq_wdata [2];
  bit            pq_we    [2];
  int            last_g, owner, waited, quiet, g;
  bit            just_issued;
  logic          e_ack [2], e_err [2];
  logic [DW-1:0] e_rdata [2];
  logic [AW-1:0] e_saddr;
  logic [DW-1:0] e_swdata;
  logic          e_swen, e_sren, e_tmo, e_ovf;

  initial begin
    last_g = 1; owner = -1; waited = 0; quiet = 0; just_issued = 0;
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      e_ack[i] = 1'b0; e_err[i] = 1'b0; e_rdata[i] = '0;
    end
    e_swen = 1'b0; e_sren = 1'b0; e_tmo = 1'b0; e_ovf = 1'b0;
    if (!rstn) begin
      for (int i = 0; i < 2; i++) pq_valid[i] = 0;
      last_g = 1; owner = -1; waited = 0; quiet = 0; just_issued = 0;
      e_saddr = '0; e_swdata = '0;
    end else begin
      // requests enter the queue (1 deep) or are dropped
      for (int i = 0; i < 2; i++) begin
        if (m_wen[i] || m_ren[i]) begin
          if (pq_valid[i]) e_ovf = 1'b1;
          else begin
            pq_valid[i] = 1; pq_addr[i] = m_addr[i];
            pq_wdata[i] = m_wdata[i]; pq_we[i] = m_wen[i];
          end
        end
      end
      if (just_issued) begin
        just_issued = 0; waited = 0;
      end else if (owner >= 0) begin
        if (s_ack) begin
          e_ack[owner] = 1'b1; e_err[owner] = s_err; e_rdata[owner] = s_rdata;
          pq_valid[owner] = 0; last_g = owner; owner = -1;
        end else if (waited == TMO - 1) begin
          e_ack[owner] = 1'b1; e_err[owner] = 1'b1; e_tmo = 1'b1;
          pq_valid[owner] = 0; last_g = owner; owner = -1; quiet = RCV;
        end else begin
          waited++;
        end
      end else if (quiet > 0) begin
        quiet--;
      end else if (pq_valid[0] || pq_valid[1]) begin
        if (pq_valid[0] && pq_valid[1]) g = 1 - last_g;
        else g = pq_valid[0] ? 0 : 1;
        owner = g; just_issued = 1;
        e_saddr = pq_addr[g]; e_swdata = pq_wdata[g];
        if (pq_we[g]) e_swen = 1'b1; else e_sren = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare --------------------------------------
  always @(posedge clk) begin
    #1;
    chk("m0_ack", m0_ack, e_ack[0]);
    chk("m0_err", m0_err, e_err[0]);
    chk("m0_rdata", m0_rdata, e_rdata[0]);
    chk("m1_ack", m1_ack, e_ack[1]);
    chk("m1_err", m1_err, e_err[1]);
    chk("m1_rdata", m1_rdata, e_rdata[1]);
    chk("s_addr", s_addr, e_saddr);
    chk("s_wdata", s_wdata, e_swdata);
    chk("s_wen", s_wen, e_swen);
    chk("s_ren", s_ren, e_sren);
    chk("stat_tmo", stat_tmo, e_tmo);
    chk("stat_ovf", stat_ovf, e_ovf);
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic drive(input int m, input bit we, input logic [31:0] a, input logic [31:0] d);
    m_addr[m] = a; m_wdata[m] = d; m_wen[m] = we; m_ren[m] = ~we;
  endtask

  task automatic release_strobes();
    for (int i = 0; i < 2; i++) begin
      m_wen[i] = 1'b0; m_ren[i] = 1'b0;
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  int cnt_ack, cnt_ovf;

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_addr[i] = '0; m_wdata[i] = '0; m_wen[i] = 1'b0; m_ren[i] = 1'b0;
    end
    // reset state
    step(3);
    chk("rst_s_ren", s_ren, 0);
    chk("rst_s_addr", s_addr, 0);
    chk("rst_m0_ack", m0_ack, 0);
    chk("rst_stat", {stat_tmo, stat_ovf}, 0);
    rstn = 1'b1;
    step(2);

    // single m0 read of 0x30, slave answers one cycle after the strobe
    slv_delay = 1; s_rdata = 32'h5A; s_err = 1'b0;
    drive(0, 0, 32'h30, 32'h0); step(1); release_strobes();
    chk("rd_sren_T1", s_ren, 1);
    chk("rd_saddr_T1", s_addr, 32'h30);
    step(1);
    chk("rd_sren_T2", s_ren, 0);
    step(1);
    chk("rd_ack_T3", m0_ack, 1);
    chk("rd_rdata_T3", m0_rdata, 32'h5A);
    chk("rd_err_T3", m0_err, 0);
    step(3);

    // fresh reset, then both requesters in the same cycle: m0 first
    rstn = 1'b0; step(1); rstn = 1'b1; step(1);
    s_rdata = 32'h1111_2222;
    drive(0, 1, 32'h10, 32'hCAFE_0010); drive(1, 0, 32'h00, 32'h0);
    step(1); release_strobes();
    chk("both_swen_T1", s_wen, 1);
    chk("both_saddr_T1", s_addr, 32'h10);
    chk("both_swdata_T1", s_wdata, 32'hCAFE_0010);
    step(2);
    chk("both_m0ack_T3", m0_ack, 1);
    step(1);
    chk("both_sren_T4", s_ren, 1);
    chk("both_saddr_T4", s_addr, 32'h0);
    step(2);
    chk("both_m1ack_T6", m1_ack, 1);
    chk("both_m1rdata_T6", m1_rdata, 32'h1111_2222);
    step(3);

    // lone m0 read returning a slave error
    s_err = 1'b1; s_rdata = 32'hBAD0;
    drive(0, 0, 32'h20, 32'h0); step(1); release_strobes();
    step(2);
    chk("err_m0ack", m0_ack, 1);
    chk("err_m0err", m0_err, 1);
    s_err = 1'b0;
    step(3);

    // both again with m0 granted last: m1 goes first
    s_rdata = 32'h0000_0404;
    drive(0, 0, 32'h04, 32'h0); drive(1, 1, 32'h08, 32'h0808_0808);
    step(1); release_strobes();
    chk("rr_swen_T1", s_wen, 1);
    chk("rr_saddr_T1", s_addr, 32'h08);
    step(2);
    chk("rr_m1ack_T3", m1_ack, 1);
    step(1);
    chk("rr_sren_T4", s_ren, 1);
    chk("rr_saddr_T4", s_addr, 32'h04);
    step(2);
    chk("rr_m0ack_T6", m0_ack, 1);
    chk("rr_m0rdata_T6", m0_rdata, 32'h0000_0404);
    step(3);

    // slave never answers: timeout 9 cycles after issue, ack in RECOVER ignored
    slv_delay = 0;
    drive(1, 0, 32'h0C, 32'h0); step(1); release_strobes();
    chk("tmo_sren_I", s_ren, 1);
    step(8);
    chk("tmo_noack_I8", m1_ack, 0);
    step(1);
    chk("tmo_m1ack_I9", m1_ack, 1);
    chk("tmo_m1err_I9", m1_err, 1);
    chk("tmo_rdata_I9", m1_rdata, 0);
    chk("tmo_stat_I9", stat_tmo, 1);
    step(1);
    inj_ack = 1'b1; s_rdata = 32'hDEAD;
    step(1);
    inj_ack = 1'b0;
    slv_delay = 1; s_rdata = 32'h4040;
    drive(0, 0, 32'h40, 32'h0);
    chk("rcv_noack", {m0_ack, m1_ack}, 0);
    step(1); release_strobes();
    chk("rcv_noack2", {m0_ack, m1_ack}, 0);
    step(1);
    chk("rcv_hold_sren", s_ren, 0);
    step(1);
    chk("rcv_latched_sren", s_ren, 1);
    chk("rcv_latched_addr", s_addr, 32'h40);
    step(4);

    // extra m0 strobe while its access waits: one overflow, one ack
    slv_delay = 4; s_rdata = 32'h5050;
    drive(0, 0, 32'h50, 32'h0); step(1); release_strobes();
    step(1);
    drive(0, 0, 32'h44, 32'h0); step(1); release_strobes();
    chk("ovf_pulse", stat_ovf, 1);
    chk("ovf_addr_kept", s_addr, 32'h50);
    cnt_ack = 0; cnt_ovf = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      cnt_ack += int'(m0_ack);
      cnt_ovf += int'(stat_ovf);
    end
    chk("ovf_one_ack", cnt_ack, 1);
    chk("ovf_no_more", cnt_ovf, 0);
    step(2);

    // reset while waiting; the late slave ack must produce nothing
    slv_delay = 6;
    drive(1, 1, 32'h60, 32'h600D); step(1); release_strobes();
    chk("rw_swen", s_wen, 1);
    step(2);
    rstn = 1'b0; step(1); rstn = 1'b1;
    chk("rw_saddr0", s_addr, 0);
    chk("rw_swdata0", s_wdata, 0);
    cnt_ack = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      cnt_ack += int'(m0_ack) + int'(m1_ack) + int'(s_wen) + int'(s_ren);
    end
    chk("rw_silent", cnt_ack, 0);
    slv_delay = 1; s_rdata = 32'h77;
    drive(0, 0, 32'h30, 32'h0); step(1); release_strobes();
    chk("post_sren", s_ren, 1);
    step(2);
    chk("post_ack", m0_ack, 1);
    chk("post_rdata", m0_rdata, 32'h77);
    step(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
